uart_boot_loader: RTL and testbench

//  Upstream of the unified RAM's port B: receives a program image over UART and writes it into RAM

---
 rtl/uart_boot_loader.sv | 200 ++++++++++++++++++++
 tb/tb_uart_boot_loader.sv | 236 +++++++++++++++++++++++
 2 files changed

// File: rtl/uart_boot_loader.sv
// UART boot loader: receives an A5/LEN/data image, writes it to RAM port B, then releases the core.
// Optional trailing checksum byte enabled by defining BOOT_CHECKSUM_EN.
module uart_boot_loader #(
  parameter int          CLK_HZ       = 100_000_000,
  parameter int          BAUD         = 115200,
  parameter int          MAX_WORDS    = 1024,
  parameter logic [31:0] ADDR_BASE    = 32'h0,
  parameter int          BOOT_TIMEOUT = 200_000_000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        rx_i,
  output logic [3:0]  mem_web,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_din,
  output logic        cpu_hold,
  output logic        done,
  output logic        error
);
  localparam int BIT_CYC = CLK_HZ / BAUD;
  localparam int CW = $clog2(BIT_CYC) + 1;
  localparam logic [CW-1:0] C_FULL = CW'(BIT_CYC - 1);
  localparam logic [CW-1:0] C_HALF = CW'(BIT_CYC / 2 - 1);
  localparam logic [31:0] TMO_LAST = 32'(BOOT_TIMEOUT - 1);
  localparam logic [15:0] MAXW = 16'(MAX_WORDS);

  typedef enum logic [1:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP} rx_t;
  typedef enum logic [2:0] {
    S_SYNC, S_LEN_LO, S_LEN_HI, S_DATA,
`ifdef BOOT_CHECKSUM_EN
    S_CSUM,
`endif
    S_DONE, S_ERR
  } state_t;

`ifdef BOOT_CHECKSUM_EN
  localparam state_t S_AFTER = S_CSUM;
`else
  localparam state_t S_AFTER = S_DONE;
`endif

  rx_t           r_rx_st;
  logic          r_rx_meta, r_rx_sync, r_rx_last;
  logic [CW-1:0] r_bcnt;
  logic [2:0]    r_bit;
  logic [7:0]    r_shift;
  logic          r_byte_vld, r_frame_err, r_start_seen;

  state_t        r_state;
  logic [31:0]   r_tmo;
  logic [15:0]   r_len;
  logic [10:0]   r_idx;
  logic [1:0]    r_wcnt;
  logic [31:0]   r_word;
`ifdef BOOT_CHECKSUM_EN
  logic [7:0]    r_sum;
`endif
  logic [3:0]    r_mem_web;
  logic [31:0]   r_mem_addr, r_mem_din;
  logic          r_cpu_hold, r_done, r_error;

  logic          w_fall;
  logic [15:0]   w_len;
  logic [31:0]   w_word;

  assign w_fall = r_rx_last & ~r_rx_sync;
  assign w_len  = {r_shift, r_len[7:0]};
  assign w_word = {r_shift, r_word[31:8]};

  // Receiver: byte available in r_shift while r_byte_vld pulses
  always_ff @(posedge clk) begin
    if (reset) begin
      r_rx_meta    <= 1'b1;
      r_rx_sync    <= 1'b1;
      r_rx_last    <= 1'b1;
      r_rx_st      <= RX_IDLE;
      r_bcnt       <= '0;
      r_bit        <= 3'd0;
      r_shift      <= 8'h00;
      r_byte_vld   <= 1'b0;
      r_frame_err  <= 1'b0;
      r_start_seen <= 1'b0;
    end else begin
      r_rx_meta   <= rx_i;
      r_rx_sync   <= r_rx_meta;
      r_rx_last   <= r_rx_sync;
      r_byte_vld  <= 1'b0;
      r_frame_err <= 1'b0;
      case (r_rx_st)
        RX_IDLE: if (w_fall) begin
          r_rx_st      <= RX_START;
          r_bcnt       <= '0;
          r_start_seen <= 1'b1;
        end
        RX_START: if (r_bcnt == C_HALF) begin
          r_bcnt  <= '0;
          r_bit   <= 3'd0;
          r_rx_st <= r_rx_sync ? RX_IDLE : RX_DATA;
        end else r_bcnt <= r_bcnt + CW'(1);
        RX_DATA: if (r_bcnt == C_FULL) begin
          r_bcnt  <= '0;
          r_shift <= {r_rx_sync, r_shift[7:1]};
          r_bit   <= r_bit + 3'd1;
          if (r_bit == 3'd7) r_rx_st <= RX_STOP;
        end else r_bcnt <= r_bcnt + CW'(1);
        RX_STOP: if (r_bcnt == C_FULL) begin
          r_bcnt      <= '0;
          r_rx_st     <= RX_IDLE;
          r_byte_vld  <= r_rx_sync;
          r_frame_err <= ~r_rx_sync;
        end else r_bcnt <= r_bcnt + CW'(1);
        default: r_rx_st <= RX_IDLE;
      endcase
    end
  end

  // Loader FSM; done/error/cpu_hold follow the terminal state one cycle later
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state    <= S_SYNC;
      r_tmo      <= 32'd0;
      r_len      <= 16'd0;
      r_idx      <= 11'd0;
      r_wcnt     <= 2'd0;
      r_word     <= 32'd0;
`ifdef BOOT_CHECKSUM_EN
      r_sum      <= 8'h00;
`endif
      r_mem_web  <= 4'h0;
      r_mem_addr <= 32'd0;
      r_mem_din  <= 32'd0;
      r_cpu_hold <= 1'b1;
      r_done     <= 1'b0;
      r_error    <= 1'b0;
    end else begin
      r_mem_web <= 4'h0;
      if (r_frame_err && r_state != S_DONE && r_state != S_ERR) begin
        r_state <= S_ERR;
      end else begin
        case (r_state)
          S_SYNC: begin
            if (r_byte_vld && r_shift == 8'hA5) r_state <= S_LEN_LO;
            else if (!r_start_seen) begin
              if (r_tmo == TMO_LAST) r_state <= S_DONE;
              else r_tmo <= r_tmo + 32'd1;
            end
          end
          S_LEN_LO: if (r_byte_vld) begin
            r_len[7:0] <= r_shift;
            r_state    <= S_LEN_HI;
          end
          S_LEN_HI: if (r_byte_vld) begin
            r_len  <= w_len;
            r_idx  <= 11'd0;
            r_wcnt <= 2'd0;
`ifdef BOOT_CHECKSUM_EN
            r_sum  <= 8'h00;
`endif
            if (w_len == 16'd0) r_state <= S_AFTER;
            else if (w_len > MAXW) r_state <= S_ERR;
            else r_state <= S_DATA;
          end
          S_DATA: if (r_byte_vld) begin
            r_word <= w_word;
            r_wcnt <= r_wcnt + 2'd1;
`ifdef BOOT_CHECKSUM_EN
            r_sum  <= r_sum + r_shift;
`endif
            if (r_wcnt == 2'd3) begin
              r_mem_web  <= 4'hF;
              r_mem_din  <= w_word;
              r_mem_addr <= ADDR_BASE + {19'd0, r_idx, 2'b00};
              r_idx      <= r_idx + 11'd1;
              if ({5'd0, r_idx} + 16'd1 == r_len) r_state <= S_AFTER;
            end
          end
`ifdef BOOT_CHECKSUM_EN
          S_CSUM: if (r_byte_vld) r_state <= (r_shift == r_sum) ? S_DONE : S_ERR;
`endif
          S_DONE: begin
            r_cpu_hold <= 1'b0;
            r_done     <= 1'b1;
          end
          S_ERR: begin
            r_cpu_hold <= 1'b1;
            r_error    <= 1'b1;
          end
          default: r_state <= S_ERR;
        endcase
      end
    end
  end

  assign mem_web  = r_mem_web;
  assign mem_addr = r_mem_addr;
  assign mem_din  = r_mem_din;
  assign cpu_hold = r_cpu_hold;
  assign done     = r_done;
  assign error    = r_error;
endmodule

// File: tb/tb_uart_boot_loader.sv
// Bench for uart_boot_loader: scoreboarded RAM writes against a frame-parsing reference model.
`timescale 1ns/1ps
module tb_uart_boot_loader;
  localparam int BIT_CYC = 8;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        rx_i = 1'b1;
  logic [3:0]  mem_web;
  logic [31:0] mem_addr, mem_din;
  logic        cpu_hold, done, error;

  uart_boot_loader #(
    .CLK_HZ(800), .BAUD(100), .MAX_WORDS(1024), .ADDR_BASE(32'h0), .BOOT_TIMEOUT(2000)
  ) dut (
    .clk(clk), .reset(reset), .rx_i(rx_i), .mem_web(mem_web), .mem_addr(mem_addr),
    .mem_din(mem_din), .cpu_hold(cpu_hold), .done(done), .error(error)
  );

  always #5 clk = ~clk;

  typedef logic [7:0] bq_t[$];
  typedef struct packed {logic [31:0] addr; logic [31:0] din;} wr_t;
  wr_t exp_q[$];
  int  n_checks = 0;
  int  n_errors = 0;
  int  cyc = 0;
  int  last_wr_cyc = -1;
  int  done_rise_cyc = -1;
  logic prev_done = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Monitor: every write pulse must match the next expected write
  always @(negedge clk) begin
    wr_t e;
    cyc++;
    if (!reset) begin
      if (mem_web != 4'h0) begin
        check("web_value", 32'(mem_web), 32'hF);
        if (exp_q.size() == 0) check("unexpected_write", 32'(exp_q.size()), 32'd1);
        else begin
          e = exp_q.pop_front();
          check("write_addr", mem_addr, e.addr);
          check("write_din", mem_din, e.din);
        end
        last_wr_cyc = cyc;
      end
      if (done && !prev_done) done_rise_cyc = cyc;
    end
    prev_done = done;
  end

  task automatic wait_cyc(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic send_byte(input logic [7:0] b, input bit stop_ok);
    rx_i = 1'b0;
    wait_cyc(BIT_CYC);
    for (int i = 0; i < 8; i++) begin
      rx_i = b[i];
      wait_cyc(BIT_CYC);
    end
    rx_i = stop_ok;
    wait_cyc(BIT_CYC);
    rx_i = 1'b1;
    wait_cyc($urandom_range(1, 6));
  endtask

  task automatic send_frame(input bq_t b);
    foreach (b[i]) send_byte(b[i], 1'b1);
  endtask

  task automatic do_reset();
    rx_i  = 1'b1;
    reset = 1'b1;
    wait_cyc(3);
    exp_q.delete();
    last_wr_cyc   = -1;
    done_rise_cyc = -1;
    reset = 1'b0;
  endtask

  task automatic check_reset_vals(input string tag);
    check({tag, "_web"}, 32'(mem_web), 32'h0);
    check({tag, "_addr"}, mem_addr, 32'h0);
    check({tag, "_din"}, mem_din, 32'h0);
    check({tag, "_hold"}, 32'(cpu_hold), 32'd1);
    check({tag, "_done"}, 32'(done), 32'd0);
    check({tag, "_error"}, 32'(error), 32'd0);
  endtask

  // Reference: parse the byte stream; st 0=still loading, 1=done, 2=error
  task automatic model(input bq_t b, output int st);
    int i;
    int n;
    logic [7:0] sum;
    wr_t w;
    st  = 0;
    i   = 0;
    sum = 8'h00;
    while (i < b.size() && b[i] != 8'hA5) i++;
    if (i + 2 >= b.size()) return;
    n = int'({b[i+2], b[i+1]});
    i += 3;
    if (n > 1024) begin
      st = 2;
      return;
    end
    for (int k = 0; k < n; k++) begin
      if (i + 4 > b.size()) return;
      w.addr = 32'(4 * k);
      w.din  = {b[i+3], b[i+2], b[i+1], b[i]};
      exp_q.push_back(w);
      sum = sum + b[i] + b[i+1] + b[i+2] + b[i+3];
      i += 4;
    end
`ifdef BOOT_CHECKSUM_EN
    if (i < b.size()) st = (b[i] == sum) ? 1 : 2;
`else
    st = 1;
`endif
  endtask

  task automatic check_status(input string tag, input int st);
    check({tag, "_done"}, 32'(done), 32'(st == 1));
    check({tag, "_error"}, 32'(error), 32'(st == 2));
    check({tag, "_hold"}, 32'(cpu_hold), 32'(st != 1));
    check({tag, "_pending_writes"}, 32'(exp_q.size()), 32'd0);
  endtask

  task automatic run_frame(input string tag, input bq_t b);
    int st;
    do_reset();
    model(b, st);
    send_frame(b);
    wait_cyc(10);
    check_status(tag, st);
  endtask

  initial begin
    bq_t b;
    int  st;
    int  n;
    logic [7:0] x, sum;

    do_reset();
    check_reset_vals("reset");

    run_frame("two_words", '{8'hA5, 8'h02, 8'h00, 8'h13, 8'h00, 8'h00, 8'h00,
                             8'h6F, 8'h00, 8'h00, 8'h00});
`ifndef BOOT_CHECKSUM_EN
    check("done_after_last_write", 32'(done_rise_cyc), 32'(last_wr_cyc + 1));
`endif

    run_frame("leading_junk", '{8'h55, 8'h00, 8'hA5, 8'h01, 8'h00, 8'hEF, 8'hBE, 8'hAD, 8'hDE});

    run_frame("too_long", '{8'hA5, 8'h01, 8'h04, 8'hA5, 8'h01, 8'h00, 8'h11, 8'h22, 8'h33, 8'h44});

    // N == MAX_WORDS is accepted: no error after the length bytes
    run_frame("max_len", '{8'hA5, 8'h00, 8'h04});

    // Idle line runs the resident image after the timeout
    do_reset();
    wait_cyc(1990);
    check("timeout_early_done", 32'(done), 32'd0);
    for (int i = 0; i < 40 && !done; i++) wait_cyc(1);
    check("timeout_done", 32'(done), 32'd1);
    check("timeout_hold", 32'(cpu_hold), 32'd0);

    // Framing error on the third byte aborts; later traffic writes nothing
    do_reset();
    send_byte(8'hA5, 1'b1);
    send_byte(8'h01, 1'b1);
    send_byte(8'h00, 1'b0);
    wait_cyc(10);
    check("frame_err_error", 32'(error), 32'd1);
    check("frame_err_hold", 32'(cpu_hold), 32'd1);
    send_frame('{8'hA5, 8'h01, 8'h00, 8'h11, 8'h22, 8'h33, 8'h44});
    wait_cyc(10);
    check("frame_err_sticky", 32'(error), 32'd1);
    check("frame_err_done", 32'(done), 32'd0);

    // Reset mid-image after one word landed
    do_reset();
    b = '{8'hA5, 8'h02, 8'h00, 8'h78, 8'h56, 8'h34, 8'h12};
    model(b, st);
    send_frame(b);
    send_byte(8'h9A, 1'b1);
    wait_cyc(3);
    check("mid_image_writes", 32'(exp_q.size()), 32'd0);
    check("mid_image_din_before_reset", mem_din, 32'h12345678);
    rx_i = 1'b0;
    wait_cyc(12);
    do_reset();
    check_reset_vals("mid_reset");

    run_frame("csum_good", '{8'hA5, 8'h01, 8'h00, 8'h01, 8'h02, 8'h03, 8'h04, 8'h0A});
    run_frame("csum_bad", '{8'hA5, 8'h01, 8'h00, 8'h01, 8'h02, 8'h03, 8'h04, 8'h0B});

    for (int it = 0; it < 8; it++) begin
      b.delete();
      for (int p = 0; p < int'($urandom_range(0, 2)); p++) begin
        x = 8'($urandom_range(0, 255));
        b.push_back(x == 8'hA5 ? 8'h5A : x);
      end
      n = int'($urandom_range(0, 4));
      b.push_back(8'hA5);
      b.push_back(8'(n));
      b.push_back(8'h00);
      sum = 8'h00;
      for (int k = 0; k < 4 * n; k++) begin
        x = 8'($urandom_range(0, 255));
        b.push_back(x);
        sum = sum + x;
      end
`ifdef BOOT_CHECKSUM_EN
      b.push_back(($urandom_range(0, 3) == 0) ? sum + 8'd1 : sum);
`else
      if ($urandom_range(0, 1) == 1) b.push_back(8'($urandom_range(0, 255)));
`endif
      run_frame($sformatf("rand%0d", it), b);
    end

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end
endmodule
